// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: status word bit positions,
// IO word-address bit and a helper that packs the status word.
package uart_tx_fifo_pkg;

  localparam int UART_ST_LEVEL_LSB = 0;
  localparam int UART_ST_EMPTY_bit = 8;
  localparam int UART_ST_FULL_bit  = 9;
  localparam int UART_ST_OVF_bit   = 10;
  localparam int IO_UART_STAT_bit  = 3;

  // Status word as seen by the IO read mux; unused bits read as 0.
  function automatic logic [31:0] uart_status_word(input logic [4:0] lvl,
                                                   input logic       emp,
                                                   input logic       ful,
                                                   input logic       ovf);
    logic [31:0] st;
    st = '0;
    st[UART_ST_LEVEL_LSB +: 5] = lvl;
    st[UART_ST_EMPTY_bit]      = emp;
    st[UART_ST_FULL_bit]       = ful;
    st[UART_ST_OVF_bit]        = ovf;
    return st;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Generic synchronous show-ahead FIFO: LUTRAM-style array with asynchronous
// read at the read index, wrap-bit pointers, status from registered pointers.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] rp;
  logic [DEPTH_LOG2:0] wp;

  // Pointer update; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rp <= '0;
      wp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // Array write; contents only cleared when initialization is configured.
  always_ff @(posedge clk) begin
`ifdef CONFIG_INITIALIZE
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wp[DEPTH_LOG2-1:0]] <= din;
    end
`else
    if (push && !reset) mem[wp[DEPTH_LOG2-1:0]] <= din;
`endif
  end

  assign dout  = mem[rp[DEPTH_LOG2-1:0]];
  assign level = wp - rp;
  assign empty = (wp == rp);
  assign full  = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) &&
                 (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: qualifies CPU pushes and emitter pops around a
// sync_fifo, keeps a sticky overflow flag and builds the status word.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  clr_ovf,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [31:0]           status
);

  logic pop;
  logic push;
  logic drop;
  logic [4:0] level5;

  assign o_valid = !empty;
  assign pop     = o_valid & i_ready;
  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when the head leaves.
  assign push    = wr_valid & (!full | pop);
  assign drop    = wr_valid & full & !pop;

  sync_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (WIDTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (wr_data),
    .dout (o_data),
    .level(level),
    .full (full),
    .empty(empty)
  );

  // Sticky overflow: a dropped write takes priority over a clear.
  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  assign level5 = 5'(level);
  assign status = uart_status_word(level5, empty, full, overflow);

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit buffer between the CPU's memory-mapped IO write port and `corescore_emitter_uart`. CPU writes to the UART data word are pushed into a synchronous FIFO instead of going straight to the emitter. The FIFO drains bytes to the emitter through its valid/ready handshake. A status word (level, full, empty, sticky overflow) is exposed for the IO read mux, so firmware polls FIFO space instead of the emitter busy bit.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `WIDTH`, 8: byte width of each entry.

Ports:
- `clk` in 1: CPU clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `wr_valid` in 1: push strobe; SOC drives `IO_mem_wr & IO_wordaddr[IO_UART_DAT_bit]`.
- `wr_data` in WIDTH: byte to push (`IO_mem_wdata[7:0]`).
- `clr_ovf` in 1: clears the sticky overflow flag.
- `o_data` out WIDTH: head byte, to emitter `i_data`.
- `o_valid` out 1: head is valid, to emitter `i_valid`.
- `i_ready` in 1: emitter `o_ready`.
- `level` out DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `full` out 1: level == 2^DEPTH_LOG2.
- `empty` out 1: level == 0.
- `overflow` out 1: sticky; set when a push is dropped.

## Operation
- Storage: 2^DEPTH_LOG2 x WIDTH array.
  - Read pointer `rp` and write pointer `wp` are DEPTH_LOG2+1 bits wide, including a wrap bit.
  - `level = wp - rp`, modulo 2^(DEPTH_LOG2+1).
  - Full when the indices match and the wrap bits differ; empty when the pointers are equal.
- Pop condition: `pop = o_valid & i_ready`. This is the transfer cycle; the emitter latches `o_data` in the same cycle.
- Push condition: `push = wr_valid & (!full | pop)`. When the FIFO is full and a pop happens in the same cycle, the push is accepted.
- Dropped write: `wr_valid & full & !pop`.
  - The byte is discarded and no pointer changes.
  - `overflow` is set at the next edge.
- `clr_ovf`:
  - Clears `overflow` at the next edge.
  - A drop in the same cycle wins: `overflow` stays 1.
- Show-ahead: `o_data` is always `mem[rp index]`. `o_valid = !empty`.
- Simultaneous push and pop at any level: level is unchanged and both pointers advance.
- Pointer wrap-around is natural modulo arithmetic; no special case.
- Write to an empty FIFO with `i_ready` = 1: the byte is not bypassed. It appears on `o_data`/`o_valid` one cycle later.
- Reset:
  - `rp = wp = 0`, `overflow = 0`.
  - Array contents are don't-care, initialized to 0 under `CONFIG_INITIALIZE`.
  - Reset mid-transfer discards all queued bytes. A byte already latched by the emitter completes on its own.
- Status word for the IO read mux, bit positions fixed:
  - [4:0] = `level` (zero-extended if DEPTH_LOG2 < 4).
  - [8] = `empty`.
  - [9] = `full`, the same bit position firmware already polls as busy.
  - [10] = `overflow`.
  - All other bits 0.

## Timing
- Reset values: `o_valid` = 0, `empty` = 1, `full` = 0, `level` = 0, `overflow` = 0. `o_data` is don't-care (0 under `CONFIG_INITIALIZE`).
- Push latency: byte written at edge N.
  - `o_valid` and `level` update after edge N.
  - The earliest pop is the cycle after N.
- Pop: accepted at the edge where `o_valid & i_ready` holds. `o_data`/`o_valid` reflect the next entry after that edge.
- `o_valid` never drops without a pop. `o_data` stays stable while `o_valid & !i_ready`.
- All outputs come from registers or pointer compares; no combinational path from `wr_valid` to `o_valid`.
- Maximum throughput: one push and one pop per cycle. Real drain is paced by the emitter (one byte per baud frame).
- Must close timing at 160 MHz on Arty.
  - The array is inferred as LUTRAM with an asynchronous read of the `rp` index.
  - The `full`/`empty` compares use registered pointers only.

## Structure
- Shared header `uart_fifo_defs.vh`: localparams for status bit positions (`UART_ST_LEVEL_LSB=0`, `UART_ST_EMPTY_bit=8`, `UART_ST_FULL_bit=9`, `UART_ST_OVF_bit=10`) and a new IO word-address bit `IO_UART_STAT_bit=3`.
- Sub-module `sync_fifo`:
  - Generic array plus pointers.
  - Ports: `clk`, `reset`, `push`, `pop`, `din`, `dout`, `level`, `full`, `empty`.
- `uart_tx_fifo` wraps `sync_fifo` and adds the push/pop qualification, the overflow flag and the status word.

## Test plan
- Reset with `wr_valid` asserted:
  - During reset, no push occurs.
  - After reset deasserts: `level` = 0, `empty` = 1, `o_valid` = 0, `overflow` = 0.
- Single byte, `i_ready` held at 1:
  - Push 0x41 at edge N.
  - `o_valid` = 1 with `o_data` = 0x41 in cycle N+1.
  - Popped at edge N+1; `empty` = 1 after it.
- Fill with `i_ready` = 0:
  - Push 0x00..0x0F: `full` = 1, `level` = 16.
  - 17th push of 0xAA: dropped, `overflow` = 1, `level` stays 16.
  - Release `i_ready`: output order is 0x00..0x0F, with no 0xAA.
- Push while full with simultaneous pop:
  - The push is accepted, `level` stays 16 and `overflow` stays 0.
  - The pushed byte emerges last.
- Wrap-around:
  - Stream 40 bytes with random `i_ready` and random `wr_valid`, never overflowing.
  - Output sequence equals input sequence; `level` never exceeds 16.
- Overflow clear priority:
  - `clr_ovf` alone: `overflow` 1 -> 0.
  - `clr_ovf` in the same cycle as a dropped write: `overflow` stays 1.
